// File: rtl/adsr_cmd_decoder.sv
// Byte-framed command parser feeding the ADSR sawtooth generator.
// Frames are SYNC, CMD, DATA, CHK with CHK = CMD + DATA (mod 256).
module adsr_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [5:0] FREQ_DEFAULT   = 6'd33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] attack_time,
    output logic [7:0] decay_time,
    output logic [7:0] sustain_level,
    output logic [7:0] release_time,
    output logic [5:0] freq_select,
    output logic       note_on,
    output logic       note_off,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CMD,
        WAIT_DATA,
        WAIT_CHK,
        COMMIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    attack_q, attack_d;
    logic [7:0]    decay_q, decay_d;
    logic [7:0]    sustain_q, sustain_d;
    logic [7:0]    release_q, release_d;
    logic [5:0]    freq_q, freq_d;
    logic          note_on_q, note_on_d;
    logic          note_off_q, note_off_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [7:0]    chk_exp;
    logic          is_sync;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        attack_d   = attack_q;
        decay_d    = decay_q;
        sustain_d  = sustain_q;
        release_d  = release_q;
        freq_d     = freq_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        chk_exp    = cmd_q + data_q;
        is_sync    = rx_valid && (rx_data == SYNC_BYTE);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (is_sync) state_d = WAIT_CMD;
            end
            WAIT_CMD, WAIT_DATA, WAIT_CHK: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (state_q == WAIT_CMD) begin
                        cmd_d   = rx_data;
                        state_d = WAIT_DATA;
                    end else if (state_q == WAIT_DATA) begin
                        data_d  = rx_data;
                        state_d = WAIT_CHK;
                    end else if (rx_data == chk_exp) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (cnt_q == TMAX) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                ok_d = 1'b1;
                case (cmd_q)
                    8'h01: attack_d  = data_q;
                    8'h02: decay_d   = data_q;
                    8'h03: sustain_d = data_q;
                    8'h04: release_d = data_q;
                    8'h05: begin
                        if (data_q <= 8'd47) freq_d = data_q[5:0];
                        else begin
                            ok_d  = 1'b0;
                            err_d = 1'b1;
                        end
                    end
                    8'h10: note_on_d  = 1'b1;
                    8'h11: note_off_d = 1'b1;
                    default: begin
                        ok_d  = 1'b0;
                        err_d = 1'b1;
                    end
                endcase
                // A byte landing here is handled as if already back in IDLE
                cnt_d   = '0;
                state_d = is_sync ? WAIT_CMD : IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            attack_q   <= '0;
            decay_q    <= '0;
            sustain_q  <= '0;
            release_q  <= '0;
            freq_q     <= FREQ_DEFAULT;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            attack_q   <= attack_d;
            decay_q    <= decay_d;
            sustain_q  <= sustain_d;
            release_q  <= release_d;
            freq_q     <= freq_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign attack_time   = attack_q;
    assign decay_time    = decay_q;
    assign sustain_level = sustain_q;
    assign release_time  = release_q;
    assign freq_select   = freq_q;
    assign note_on       = note_on_q;
    assign note_off      = note_off_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_adsr_cmd_decoder.sv
// Bench for adsr_cmd_decoder: vector table, corner sequences and
// random frames scored against a frame-level model.
module tb_adsr_cmd_decoder;

    localparam int T = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] attack_time, decay_time, sustain_level, release_time;
    logic [5:0] freq_select;
    logic       note_on, note_off, frame_ok, frame_err, busy;

    adsr_cmd_decoder #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(T),
        .FREQ_DEFAULT  (6'd33)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .attack_time  (attack_time),
        .decay_time   (decay_time),
        .sustain_level(sustain_level),
        .release_time (release_time),
        .freq_select  (freq_select),
        .note_on      (note_on),
        .note_off     (note_off),
        .frame_ok     (frame_ok),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Pulse counters: each strobe is one cycle wide, so high cycles == events
    int ok_n = 0, err_n = 0, on_n = 0, off_n = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            ok_n  <= ok_n + int'(frame_ok);
            err_n <= err_n + int'(frame_err);
            on_n  <= on_n + int'(note_on);
            off_n <= off_n + int'(note_off);
        end
    end

    // Frame-level reference model
    logic [7:0] m_att, m_dec, m_sus, m_rel;
    logic [5:0] m_freq;
    int e_ok = 0, e_err = 0, e_on = 0, e_off = 0;

    task automatic model_reset();
        m_att = 0; m_dec = 0; m_sus = 0; m_rel = 0; m_freq = 6'd33;
    endtask

    task automatic model_frame(input logic [7:0] c, input logic [7:0] d,
                               input logic [7:0] k);
        logic [7:0] s;
        s = c + d;
        if (k != s) e_err++;
        else begin
            case (c)
                8'h01: begin m_att = d; e_ok++; end
                8'h02: begin m_dec = d; e_ok++; end
                8'h03: begin m_sus = d; e_ok++; end
                8'h04: begin m_rel = d; e_ok++; end
                8'h05: if (int'(d) < 48) begin m_freq = d[5:0]; e_ok++; end
                       else e_err++;
                8'h10: begin e_on++; e_ok++; end
                8'h11: begin e_off++; e_ok++; end
                default: e_err++;
            endcase
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_att"}, int'(attack_time), int'(m_att));
        check({tag, "_dec"}, int'(decay_time), int'(m_dec));
        check({tag, "_sus"}, int'(sustain_level), int'(m_sus));
        check({tag, "_rel"}, int'(release_time), int'(m_rel));
        check({tag, "_freq"}, int'(freq_select), int'(m_freq));
        check({tag, "_ok"}, ok_n, e_ok);
        check({tag, "_err"}, err_n, e_err);
        check({tag, "_on"}, on_n, e_on);
        check({tag, "_off"}, off_n, e_off);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    // Called at a negedge; returns at the negedge after the byte is sampled
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] k, input int gap);
        send_byte(8'hA5, gap);
        send_byte(c, gap);
        send_byte(d, gap);
        send_byte(k, gap);
    endtask

    typedef struct {
        logic [7:0] cmd, data, chk;
        int         d_ok, d_err, d_on, d_off;
        logic [7:0] att, dec, sus, rel;
        logic [5:0] freq;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int b_ok, b_err, b_on, b_off;
        logic [7:0] cmds[7];
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        model_reset();

        tbl[0]  = '{8'h01, 8'h40, 8'h41, 1, 0, 0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 6'd33};
        tbl[1]  = '{8'h02, 8'h10, 8'hFF, 0, 1, 0, 0, 8'h40, 8'h00, 8'h00, 8'h00, 6'd33};
        tbl[2]  = '{8'h02, 8'h10, 8'h12, 1, 0, 0, 0, 8'h40, 8'h10, 8'h00, 8'h00, 6'd33};
        tbl[3]  = '{8'h05, 8'h30, 8'h35, 0, 1, 0, 0, 8'h40, 8'h10, 8'h00, 8'h00, 6'd33};
        tbl[4]  = '{8'h05, 8'h21, 8'h26, 1, 0, 0, 0, 8'h40, 8'h10, 8'h00, 8'h00, 6'd33};
        tbl[5]  = '{8'h05, 8'h00, 8'h05, 1, 0, 0, 0, 8'h40, 8'h10, 8'h00, 8'h00, 6'd0};
        tbl[6]  = '{8'h05, 8'h2F, 8'h34, 1, 0, 0, 0, 8'h40, 8'h10, 8'h00, 8'h00, 6'd47};
        tbl[7]  = '{8'h10, 8'h00, 8'h10, 1, 0, 1, 0, 8'h40, 8'h10, 8'h00, 8'h00, 6'd47};
        tbl[8]  = '{8'h11, 8'h00, 8'h11, 1, 0, 0, 1, 8'h40, 8'h10, 8'h00, 8'h00, 6'd47};
        tbl[9]  = '{8'h03, 8'hA5, 8'hA8, 1, 0, 0, 0, 8'h40, 8'h10, 8'hA5, 8'h00, 6'd47};
        tbl[10] = '{8'h07, 8'h00, 8'h07, 0, 1, 0, 0, 8'h40, 8'h10, 8'hA5, 8'h00, 6'd47};
        tbl[11] = '{8'h04, 8'h80, 8'h84, 1, 0, 0, 0, 8'h40, 8'h10, 8'hA5, 8'h80, 6'd47};

        repeat (3) @(negedge clk);
        check("rst_att", int'(attack_time), 0);
        check("rst_freq", int'(freq_select), 33);
        check("rst_strobes", int'({note_on, note_off, frame_ok, frame_err}), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            b_ok = ok_n; b_err = err_n; b_on = on_n; b_off = off_n;
            send_frame(tbl[i].cmd, tbl[i].data, tbl[i].chk, i % 3);
            model_frame(tbl[i].cmd, tbl[i].data, tbl[i].chk);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_ok", i), ok_n - b_ok, tbl[i].d_ok);
            check($sformatf("v%0d_err", i), err_n - b_err, tbl[i].d_err);
            check($sformatf("v%0d_on", i), on_n - b_on, tbl[i].d_on);
            check($sformatf("v%0d_off", i), off_n - b_off, tbl[i].d_off);
            check($sformatf("v%0d_att", i), int'(attack_time), int'(tbl[i].att));
            check($sformatf("v%0d_dec", i), int'(decay_time), int'(tbl[i].dec));
            check($sformatf("v%0d_sus", i), int'(sustain_level), int'(tbl[i].sus));
            check($sformatf("v%0d_rel", i), int'(release_time), int'(tbl[i].rel));
            check($sformatf("v%0d_freq", i), int'(freq_select), int'(tbl[i].freq));
            check($sformatf("v%0d_busy", i), int'(busy), 0);
        end

        // Commit latency: CHK sampled, COMMIT cycle, then outputs update
        send_frame(8'h01, 8'h33, 8'h34, 0);
        model_frame(8'h01, 8'h33, 8'h34);
        check("lat_ok_early", int'(frame_ok), 0);
        check("lat_att_early", int'(attack_time), 8'h40);
        check("lat_busy_commit", int'(busy), 1);
        @(negedge clk);
        check("lat_ok_pulse", int'(frame_ok), 1);
        check("lat_att_new", int'(attack_time), 8'h33);
        @(negedge clk);
        check("lat_ok_drop", int'(frame_ok), 0);
        repeat (2) @(negedge clk);
        check_model("lat");

        // Back-to-back note frames, second SYNC lands in the COMMIT cycle
        send_frame(8'h10, 8'h00, 8'h10, 0);
        send_frame(8'h11, 8'h00, 8'h11, 0);
        model_frame(8'h10, 8'h00, 8'h10);
        model_frame(8'h11, 8'h00, 8'h11);
        repeat (3) @(negedge clk);
        check_model("b2b");

        // Stray bytes before a frame whose DATA equals SYNC
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h12, 0);
        send_frame(8'h03, 8'hA5, 8'hA8, 0);
        model_frame(8'h03, 8'hA5, 8'hA8);
        repeat (3) @(negedge clk);
        check_model("stray");

        // Gaps well inside the timeout window are tolerated
        send_frame(8'h01, 8'h44, 8'h45, T / 2);
        model_frame(8'h01, 8'h44, 8'h45);
        repeat (3) @(negedge clk);
        check_model("slow");

        // Abandoned frame times out with a single error
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        repeat (2 * T + 5) @(negedge clk);
        e_err++;
        check_model("tmo");
        send_frame(8'h04, 8'h90, 8'h94, 0);
        model_frame(8'h04, 8'h90, 8'h94);
        repeat (3) @(negedge clk);
        check_model("post_tmo");

        // Reset mid-frame, then leftover bytes must not complete a frame
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mrst_att", int'(attack_time), 0);
        check("mrst_rel", int'(release_time), 0);
        check("mrst_freq", int'(freq_select), 33);
        check("mrst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h80, 0);
        send_byte(8'h84, 0);
        repeat (3) @(negedge clk);
        check_model("mrst_tail");
        send_frame(8'h04, 8'h80, 8'h84, 0);
        model_frame(8'h04, 8'h80, 8'h84);
        repeat (3) @(negedge clk);
        check_model("mrst_frame");

        // Random frames
        cmds = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11};
        for (int r = 0; r < 200; r++) begin
            logic [7:0] c, d, k, s;
            int ns, kk;
            ns = $urandom_range(0, 2);
            for (int j = 0; j < ns; j++) begin
                s = 8'($urandom_range(0, 255));
                if (s == 8'hA5) s = 8'h00;
                send_byte(s, $urandom_range(0, 3));
            end
            kk = $urandom_range(0, 8);
            c = (kk < 7) ? cmds[kk] : 8'($urandom_range(0, 255));
            d = 8'($urandom_range(0, 255));
            if (c == 8'h05 && $urandom_range(0, 1) == 1)
                d = 8'($urandom_range(40, 55));
            k = c + d;
            if ($urandom_range(0, 7) == 0)
                k = k ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 19) == 0) begin
                kk = $urandom_range(1, 3);
                send_byte(8'hA5, $urandom_range(0, 3));
                if (kk > 1) send_byte(c, $urandom_range(0, 3));
                if (kk > 2) send_byte(d, $urandom_range(0, 3));
                repeat (2 * T + 5) @(negedge clk);
                e_err++;
                check_model($sformatf("rt%0d", r));
            end else begin
                send_byte(8'hA5, $urandom_range(0, 3));
                send_byte(c, $urandom_range(0, 3));
                send_byte(d, $urandom_range(0, 3));
                send_byte(k, $urandom_range(0, 3));
                model_frame(c, d, k);
                if ($urandom_range(0, 3) != 0) begin
                    repeat (3) @(negedge clk);
                    check_model($sformatf("r%0d", r));
                end
            end
        end
        repeat (3) @(negedge clk);
        check_model("rend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
